// File: rtl/candidate_acc_if.sv
// ----------------------------------------------------------------------------
// candidate_acc_if: hit-vector stream in, candidate total/done/busy out. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface candidate_acc_if #(
  parameter int ROW_W = 8,
  parameter int CNT_W = 8,
  parameter int RID_W = 3
);
  logic             start;
  logic [1:0]       mode;
  logic             cand_en;
  logic [1:0]       count;
  logic [RID_W-1:0] row_id;
  logic [ROW_W-1:0] hit;
  logic [CNT_W-1:0] candidate;
  logic             done;
  logic             busy;

  modport master (
    output start, mode, cand_en, count, row_id, hit,
    input  candidate, done, busy
  );

  modport slave (
    input  start, mode, cand_en, count, row_id, hit,
    output candidate, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/candidate_acc.sv
// ----------------------------------------------------------------------------
// candidate_acc: combines per-row A/B/C hit vectors by mode and accumulates
// their popcount. Optional macro CAND_PIPE_EN registers the combined vector. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module candidate_acc #(
  parameter int ROW_W = 8,
  parameter int ROWS  = 8,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  candidate_acc_if.slave bus
);
  localparam int               RID_W    = $clog2(ROWS);
  localparam logic [RID_W-1:0] LAST_ROW = RID_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       mode_q;
  logic [ROW_W-1:0] ha;
  logic [ROW_W-1:0] hb;
  logic [CNT_W-1:0] cand;

  logic [1:0]       tag_max;
  logic             take;
  logic             is_a;
  logic             is_b;
  logic             is_comb;
  logic             is_last;
  logic [ROW_W-1:0] r_vec;
  logic [ROW_W-1:0] add_vec;
  logic             add_en;

  function automatic logic [CNT_W-1:0] popcnt(input logic [ROW_W-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < ROW_W; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  // A always carries the highest tag the latched mode uses; C (or B) closes the row at tag 0.
  always_comb begin
    tag_max = 2'd1;
    unique case (mode_q)
      2'd0:    tag_max = 2'd0;
      2'd3:    tag_max = 2'd2;
      default: tag_max = 2'd1;
    endcase
    take    = (state == S_ACC) && bus.cand_en && !bus.start;
    is_a    = take && (bus.count == tag_max);
    is_b    = take && (((mode_q == 2'd3) && (bus.count == 2'd1)) ||
                       ((mode_q inside {2'd1, 2'd2}) && (bus.count == 2'd0)));
    is_comb = take && (bus.count == 2'd0);
    is_last = is_comb && (bus.row_id == LAST_ROW);
    r_vec   = bus.hit;
    unique case (mode_q)
      2'd0:    r_vec = bus.hit;
      2'd1:    r_vec = ha & bus.hit;
      2'd2:    r_vec = ha ^ bus.hit;
      default: r_vec = (ha & hb & ~bus.hit) | (ha & ~hb & bus.hit) | (~ha & hb & bus.hit);
    endcase
  end

`ifdef CAND_PIPE_EN
  logic [ROW_W-1:0] r_q;
  logic             r_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_vld <= 1'b0;
    end else if (bus.start) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= is_comb;
      if (is_comb) r_q <= r_vec;
    end
  end

  assign add_vec = r_q;
  assign add_en  = r_vld;
`else
  assign add_vec = r_vec;
  assign add_en  = is_comb;
`endif

  always_comb begin
    state_nx = state;
    if (bus.start) begin
      state_nx = S_ACC;
    end else begin
      unique case (state)
        S_ACC: begin
          if (is_last) begin
`ifdef CAND_PIPE_EN
            state_nx = S_DRAIN;
`else
            state_nx = S_FIN;
`endif
          end
        end
        S_DRAIN: state_nx = S_FIN;
        S_FIN:   state_nx = S_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 2'd0;
      ha     <= '0;
      hb     <= '0;
      cand   <= '0;
    end else if (bus.start) begin
      mode_q <= bus.mode;
      ha     <= '0;
      hb     <= '0;
      cand   <= '0;
    end else begin
      if (is_a)   ha   <= bus.hit;
      if (is_b)   hb   <= bus.hit;
      if (add_en) cand <= cand + popcnt(add_vec);
    end
  end

  assign bus.candidate = cand;
  assign bus.done      = (state == S_FIN);
  assign bus.busy      = (state == S_ACC) || (state == S_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_candidate_acc.sv
// ----------------------------------------------------------------------------
// tb_candidate_acc: table-driven frames with a done-triggered scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_candidate_acc;
  localparam int ROW_W = 8;
  localparam int ROWS  = 8;
  localparam int CNT_W = 8;
`ifdef CAND_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [1:0]       mode;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       c;
    logic             junk;
    logic [CNT_W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   dones    = 0;
  logic [CNT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  candidate_acc_if #(.ROW_W(ROW_W), .CNT_W(CNT_W), .RID_W(3)) bus ();

  candidate_acc #(.ROW_W(ROW_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every done pulse must match the oldest outstanding expected total.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
      end else begin
        check("candidate", int'(bus.candidate), int'(exp_q.pop_front()));
        check("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic beat(input logic st, input logic [1:0] md, input logic en,
                      input logic [1:0] cnt, input logic [2:0] rid, input logic [7:0] h);
    bus.start   = st;
    bus.mode    = md;
    bus.cand_en = en;
    bus.count   = cnt;
    bus.row_id  = rid;
    bus.hit     = h;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.cand_en = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int nrows, input int bubble_row,
                           input logic junk, input logic [CNT_W-1:0] exp);
    int lat;
    beat(1'b1, md, 1'b1, 2'd0, 3'd7, 8'hFF);
    check("busy_after_start", int'(bus.busy), 1);
    if (nrows == ROWS) exp_q.push_back(exp);
    for (int r = 0; r < nrows; r++) begin
      if (junk) beat(1'b0, md, 1'b1, (md == 2'd3) ? 2'd3 : 2'd2, 3'(r), 8'hFF);
      case (md)
        2'd0: beat(1'b0, md, 1'b1, 2'd0, 3'(r), a);
        2'd1, 2'd2: begin
          beat(1'b0, md, 1'b1, 2'd1, 3'(r), a);
          if (r == bubble_row) repeat (3) beat(1'b0, md, 1'b0, 2'd0, 3'(r), 8'h55);
          beat(1'b0, md, 1'b1, 2'd0, 3'(r), b);
        end
        default: begin
          beat(1'b0, md, 1'b1, 2'd2, 3'(r), a);
          beat(1'b0, md, 1'b1, 2'd1, 3'(r), b);
          beat(1'b0, md, 1'b1, 2'd0, 3'(r), c);
        end
      endcase
    end
    if (nrows == ROWS) begin
      lat = 1;
      while (!bus.done && lat < 6) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("done_latency", lat, EXP_LAT);
      @(posedge clk);
      #1;
      check("done_single_pulse", int'(bus.done), 0);
    end
  endtask

  initial begin
    vec_t             tbl[7];
    logic [CNT_W-1:0] last_exp;
    int               dones_before;

    tbl[0] = '{mode: 2'd0, a: 8'hFF, b: 8'h00, c: 8'h00, junk: 1'b0, exp: 8'd64};
    tbl[1] = '{mode: 2'd1, a: 8'hF0, b: 8'h3C, c: 8'h00, junk: 1'b0, exp: 8'd16};
    tbl[2] = '{mode: 2'd2, a: 8'hF0, b: 8'h3C, c: 8'h00, junk: 1'b0, exp: 8'd32};
    tbl[3] = '{mode: 2'd3, a: 8'hFF, b: 8'h0F, c: 8'h33, junk: 1'b0, exp: 8'd32};
    tbl[4] = '{mode: 2'd3, a: 8'hAA, b: 8'hCC, c: 8'hF0, junk: 1'b1, exp: 8'd24};
    tbl[5] = '{mode: 2'd0, a: 8'h01, b: 8'h00, c: 8'h00, junk: 1'b1, exp: 8'd8};
    tbl[6] = '{mode: 2'd1, a: 8'hFF, b: 8'hAA, c: 8'h00, junk: 1'b1, exp: 8'd32};

    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.cand_en = 1'b0;
    bus.count   = 2'd0;
    bus.row_id  = 3'd0;
    bus.hit     = 8'h00;
    last_exp    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_candidate", int'(bus.candidate), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, ROWS, -1, tbl[i].junk, tbl[i].exp);
      last_exp = tbl[i].exp;
    end

    // Hits while idle must not disturb the held total.
    repeat (3) beat(1'b0, 2'd0, 1'b1, 2'd0, 3'd7, 8'hFF);
    check("idle_hold", int'(bus.candidate), int'(last_exp));

    run_frame(2'd1, 8'hF0, 8'h3C, 8'h00, ROWS, 4, 1'b0, 8'd16);

    run_frame(2'd0, 8'hFF, 8'h00, 8'h00, 3, -1, 1'b0, 8'd0);
    run_frame(2'd3, 8'hFF, 8'h0F, 8'h33, ROWS, -1, 1'b0, 8'd32);

    run_frame(2'd0, 8'hFF, 8'h00, 8'h00, 5, -1, 1'b0, 8'd0);
    dones_before = dones;
    rst = 1'b0;
    #2;
    check("midrst_candidate", int'(bus.candidate), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) beat(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 8'h00);
    check("no_done_after_reset", dones, dones_before);

    run_frame(2'd0, 8'hFF, 8'h00, 8'h00, ROWS, -1, 1'b0, 8'd64);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
